dir_input_ctrl: RTL
===================

DIR_INPUT_CTRL -- requirements
Module: dir_input_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 650000, meaning the number of clock cycles a raw level must hold before it is accepted (10 ms at 65 MHz).
REQ-002 SHALL have parameter REPEAT_DELAY, default 19500000, meaning the number of cycles from the first request to the first auto-repeat request (300 ms).
REQ-003 SHALL have parameter REPEAT_PERIOD, default 6500000, meaning the number of cycles between auto-repeat requests (100 ms).
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic is rising-edge clocked.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port btn, input, 4 bits: raw asynchronous buttons, active high; [3]=up, [2]=down, [1]=left, [0]=right.
REQ-007 SHALL have port dir_ready, input, 1 bit: the downstream game-logic stage accepts the request.
REQ-008 SHALL have port dir_valid, output, 1 bit: a direction request is pending.
REQ-009 SHALL have port dir_code, output, 2 bits: the requested direction; 00=up, 01=down, 10=left, 11=right.
REQ-010 SHALL have port btn_state, output, 4 bits: the debounced button levels, same bit order as btn.

Function
REQ-011 SHALL pass each btn bit through a 2-flop synchronizer before any other use.
REQ-012 SHALL keep a per-bit debounce counter: it clears when the synced level equals the stable level, and increments otherwise.
REQ-013 SHALL set the stable bit to the synced level, and clear that bit's counter, when its counter reaches DEB_CYCLES-1 while the levels still differ.
REQ-014 SHALL drive btn_state directly from the stable bits (registered); the raw-edge-to-btn_state latency is 2+DEB_CYCLES cycles.
REQ-015 SHALL define the active direction as the highest-priority stable pressed bit, priority up > down > left > right; none pressed = no active direction.
REQ-016 SHALL implement FSM states IDLE, DELAY and REPEAT, plus an rpt_cnt counter.
REQ-017 IDLE: when an active direction exists, SHALL issue a request, clear rpt_cnt and go to DELAY.
REQ-018 DELAY: SHALL increment rpt_cnt; at REPEAT_DELAY-1 SHALL issue a request, clear rpt_cnt and go to REPEAT.
REQ-019 REPEAT: SHALL increment rpt_cnt; at REPEAT_PERIOD-1 SHALL issue a request, clear rpt_cnt and remain in REPEAT.
REQ-020 In DELAY or REPEAT, if the active direction differs from the last issued code, SHALL immediately issue a request with the new direction, clear rpt_cnt and go to DELAY; this takes precedence over REQ-018/019.
REQ-021 In DELAY or REPEAT, if no direction is active, SHALL go to IDLE and clear rpt_cnt without issuing a request; this takes precedence over REQ-020.
REQ-022 On a request issued at edge N, dir_valid SHALL be 1 and dir_code SHALL hold the new code from edge N+1.
REQ-023 SHALL hold dir_valid high and dir_code stable until a cycle with dir_valid=1 and dir_ready=1; dir_valid SHALL clear at the next edge.
REQ-024 A new request while one is pending and not accepted SHALL overwrite dir_code with the newest direction and keep dir_valid=1; no queueing.
REQ-025 Accept and new request in the same cycle SHALL leave dir_valid=1 with the new code.
REQ-026 dir_ready SHALL be ignored while dir_valid=0.
REQ-027 Simultaneous presses SHALL be resolved only by REQ-015; releasing a higher-priority button while a lower one stays held SHALL be a direction change per REQ-020.

Reset
REQ-028 While rst=1 at a rising edge, SHALL clear the synchronizers, stable bits, all counters, dir_valid, dir_code and btn_state to 0, and set the FSM to IDLE.
REQ-029 Reset mid-operation SHALL drop any pending request with no acceptance required; after reset, a held button SHALL be re-debounced from zero before any request.

Verification (DEB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, dir_ready=1 unless stated)
REQ-030 Bench SHALL cover: btn=0001 held -> btn_state=0001 after 6 cycles; one dir_valid pulse with code 11 on the next cycle; then pulses 10 and 15 cycles after the first.
REQ-031 Bench SHALL cover: btn glitch 1000 for 3 cycles then 0000 -> btn_state stays 0000; dir_valid never asserts.
REQ-032 Bench SHALL cover: btn=1010 pressed together -> code 00; release up (btn=0010) -> after debounce, immediate code 10 request; rpt_cnt restarts.
REQ-033 Bench SHALL cover: dir_ready=0 while holding down until two requests are issued -> dir_valid stays 1 with code 01; raising dir_ready gives exactly one accept, then dir_valid=0.
REQ-034 Bench SHALL cover: rst=1 for 1 cycle while in REPEAT with dir_valid=1 -> all outputs 0 next cycle; the held button produces a new request only after a full re-debounce.
REQ-035 Bench SHALL cover: release all buttons in DELAY just before rpt_cnt=9 -> FSM returns to IDLE and no repeat request is issued.

Source files
------------

// File: rtl/dir_input_ctrl.sv
// dir_input_ctrl: debounces four direction buttons and issues prioritised
// direction requests with auto-repeat over a valid/ready handshake.
module dir_input_ctrl #(
    parameter int DEB_CYCLES    = 650000,
    parameter int REPEAT_DELAY  = 19500000,
    parameter int REPEAT_PERIOD = 6500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic       dir_ready,
    output logic       dir_valid,
    output logic [1:0] dir_code,
    output logic [3:0] btn_state
);
    localparam int DW   = $clog2(DEB_CYCLES + 1);
    localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    logic [3:0]          r_sync1, r_sync2, r_stable;
    logic [3:0][DW-1:0]  r_deb_cnt;
    state_t              r_state, w_state_n;
    logic [RW-1:0]       r_rpt_cnt, w_rpt_cnt_n;
    logic                r_valid;
    logic [1:0]          r_code;
    logic                w_act, w_issue;
    logic [1:0]          w_dir;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_stable  <= '0;
            r_deb_cnt <= '0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_LAST) begin
                    r_stable[i]  <= r_sync2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Priority up > down > left > right
    assign w_act = |r_stable;
    assign w_dir = r_stable[3] ? 2'd0 : r_stable[2] ? 2'd1 : r_stable[1] ? 2'd2 : 2'd3;

    // Release beats direction change, which beats the repeat timer
    always_comb begin
        w_state_n   = r_state;
        w_rpt_cnt_n = '0;
        w_issue     = 1'b0;
        if (r_state == IDLE) begin
            if (w_act) begin
                w_issue   = 1'b1;
                w_state_n = DELAY;
            end
        end else if (!w_act) begin
            w_state_n = IDLE;
        end else if (w_dir != r_code) begin
            w_issue   = 1'b1;
            w_state_n = DELAY;
        end else if (r_rpt_cnt == (r_state == DELAY ? DELAY_LAST : PERIOD_LAST)) begin
            w_issue   = 1'b1;
            w_state_n = REPEAT;
        end else begin
            w_rpt_cnt_n = r_rpt_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_rpt_cnt <= '0;
            r_valid   <= 1'b0;
            r_code    <= 2'd0;
        end else begin
            r_state   <= w_state_n;
            r_rpt_cnt <= w_rpt_cnt_n;
            if (w_issue) begin
                r_valid <= 1'b1;
                r_code  <= w_dir;
            end else if (dir_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign dir_valid = r_valid;
    assign dir_code  = r_code;
    assign btn_state = r_stable;
endmodule
